// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the EX/MEM pipeline stage. Holds the
//               default datapath widths, the stage FSM encoding and the packed
//               beat record carried through the main and skid slots.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int C_DATA_W = 32;
    localparam int C_ADDR_W = 5;

    // Stage occupancy: nothing held, main slot only, main plus skid slot.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } ex_mem_state_t;

    // One instruction's worth of MEM/WB payload.
    typedef struct packed {
        logic [C_DATA_W-1:0] alu_data;
        logic [C_DATA_W-1:0] st_data;
        logic [C_ADDR_W-1:0] rd_addr;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                zero;
    } ex_mem_beat_t;

endpackage
`default_nettype wire

// File: rtl/ex_mem_slot.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_slot
// Description : Load-enabled register holding one ex_mem_beat_t. Used twice in
//               the EX/MEM stage, once as the main slot and once as the skid
//               slot. Cleared on reset so outputs are deterministic.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_slot
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  ex_mem_beat_t i_beat,
    output ex_mem_beat_t o_beat
);

    ex_mem_beat_t r_beat;

    // Capture a new beat when loaded; reset clears the slot asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat <= '0;
        end else if (i_load) begin
            r_beat <= i_beat;
        end
    end

    assign o_beat = r_beat;

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage
// Description : Skid-buffered EX -> MEM pipeline register with valid/ready on
//               both sides. A registered-only ready_o keeps the upstream timing
//               path free of ready_i; the skid slot absorbs the one beat that
//               can arrive while downstream stalls. flush_i empties the stage.
//               Optional feature macro: EXMEM_ZERO_FLAG_EN (registered
//               alu_data==0 flag on zero_o; when undefined zero_o is 0).
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int ADDR_W = C_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] alu_data_o,
    output logic [DATA_W-1:0] st_data_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              zero_o
);

    ex_mem_state_t r_state;
    ex_mem_state_t w_state_next;

    logic         w_fire_in;
    logic         w_fire_out;
    logic         w_main_load;
    logic         w_main_from_skid;
    logic         w_skid_load;
    ex_mem_beat_t w_in_beat;
    ex_mem_beat_t w_main_d;
    ex_mem_beat_t w_main_q;
    ex_mem_beat_t w_skid_q;

    // Handshake decode comes only from registered state (and reset).
    assign ready_o    = (r_state != TWO) & ~rst_i;
    assign valid_o    = (r_state != EMPTY);
    assign w_fire_in  = valid_i & ready_o;
    assign w_fire_out = valid_o & ready_i;

    // Incoming beat; x0 is never a write-back target, so its enable is dropped.
    always_comb begin
        w_in_beat           = '0;
        w_in_beat.alu_data  = alu_data_i;
        w_in_beat.st_data   = st_data_i;
        w_in_beat.rd_addr   = rd_addr_i;
        w_in_beat.reg_write = reg_write_i & (rd_addr_i != '0);
        w_in_beat.mem_read  = mem_read_i;
        w_in_beat.mem_write = mem_write_i;
`ifdef EXMEM_ZERO_FLAG_EN
        w_in_beat.zero      = (alu_data_i == '0);
`else
        // Constant-fed flag bit: the comparator and flag flops fold away.
        w_in_beat.zero      = 1'b0;
`endif
    end

    // Occupancy register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and slot load control; flush overrides every transition.
    always_comb begin
        w_state_next     = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (flush_i) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_fire_in) begin
                        w_state_next = ONE;
                        w_main_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (w_fire_in && w_fire_out) begin
                        w_main_load  = 1'b1;
                    end else if (w_fire_in) begin
                        w_state_next = TWO;
                        w_skid_load  = 1'b1;
                    end else if (w_fire_out) begin
                        w_state_next = EMPTY;
                    end
                end
                TWO: begin
                    // The older beat leaves; the skid beat moves up to main.
                    if (w_fire_out) begin
                        w_state_next     = ONE;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                end
            endcase
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_beat;

    ex_mem_slot u_main (
        .clk    (clk_i),
        .rst    (rst_i),
        .i_load (w_main_load),
        .i_beat (w_main_d),
        .o_beat (w_main_q)
    );

    ex_mem_slot u_skid (
        .clk    (clk_i),
        .rst    (rst_i),
        .i_load (w_skid_load),
        .i_beat (w_in_beat),
        .o_beat (w_skid_q)
    );

    // All downstream payload comes from the main slot only.
    assign alu_data_o  = w_main_q.alu_data;
    assign st_data_o   = w_main_q.st_data;
    assign rd_addr_o   = w_main_q.rd_addr;
    assign reg_write_o = w_main_q.reg_write;
    assign mem_read_o  = w_main_q.mem_read;
    assign mem_write_o = w_main_q.mem_write;
    assign zero_o      = w_main_q.zero;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Self-checking bench for ex_mem_stage: a table of directed
//               per-cycle vectors plus hand sequences for flush in the full
//               state and asynchronous reset during a stall.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

`ifdef EXMEM_ZERO_FLAG_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] alu_data_i;
    logic [31:0] st_data_i;
    logic [4:0]  rd_addr_i;
    logic        reg_write_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] alu_data_o;
    logic [31:0] st_data_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        zero_o;

    int checks = 0;
    int errors = 0;

    ex_mem_stage dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .alu_data_i  (alu_data_i),
        .st_data_i   (st_data_i),
        .rd_addr_i   (rd_addr_i),
        .reg_write_i (reg_write_i),
        .mem_read_i  (mem_read_i),
        .mem_write_i (mem_write_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .alu_data_o  (alu_data_o),
        .st_data_o   (st_data_o),
        .rd_addr_o   (rd_addr_o),
        .reg_write_o (reg_write_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .zero_o      (zero_o)
    );

    always #5 clk = ~clk;

    // Upstream must never present a beat that is both load and store.
    always @(negedge clk) begin
        if (!rst_i && valid_i) begin
            assert (!(mem_read_i && mem_write_i));
        end
    end

    typedef struct {
        logic        flush;
        logic        valid;
        logic        rdy;
        logic [31:0] alu;
        logic [31:0] st;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_alu;
        logic [31:0] e_st;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic        e_mr;
        logic        e_mw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic flush, input logic valid, input logic rdy,
        input logic [31:0] alu, input logic [31:0] st, input logic [4:0] rd,
        input logic rw, input logic mr, input logic mw,
        input logic e_ready, input logic e_valid,
        input logic [31:0] e_alu, input logic [31:0] e_st, input logic [4:0] e_rd,
        input logic e_rw, input logic e_mr, input logic e_mw);
        vec_t v;
        v.flush = flush;  v.valid = valid;  v.rdy = rdy;
        v.alu = alu;  v.st = st;  v.rd = rd;
        v.rw = rw;  v.mr = mr;  v.mw = mw;
        v.e_ready = e_ready;  v.e_valid = e_valid;
        v.e_alu = e_alu;  v.e_st = e_st;  v.e_rd = e_rd;
        v.e_rw = e_rw;  v.e_mr = e_mr;  v.e_mw = e_mw;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        flush_i     = v.flush;
        valid_i     = v.valid;
        ready_i     = v.rdy;
        alu_data_i  = v.alu;
        st_data_i   = v.st;
        rd_addr_i   = v.rd;
        reg_write_i = v.rw;
        mem_read_i  = v.mr;
        mem_write_i = v.mw;
    endtask

    task automatic send(input logic valid, input logic rdy, input logic flush,
                        input logic [31:0] alu, input logic [4:0] rd);
        drive(mk(flush, valid, rdy, alu, 32'h0, rd, 1'b1, 1'b0, 1'b0,
                 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] alu, input logic [31:0] st,
                              input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
        logic exp_zero;
        exp_zero = ZF && (alu == 32'h0);
        check({tag, " alu_data_o"},  alu_data_o,  alu);
        check({tag, " st_data_o"},   st_data_o,   st);
        check({tag, " rd_addr_o"},   {27'h0, rd_addr_o}, {27'h0, rd});
        check({tag, " reg_write_o"}, {31'h0, reg_write_o}, {31'h0, rw});
        check({tag, " mem_read_o"},  {31'h0, mem_read_o},  {31'h0, mr});
        check({tag, " mem_write_o"}, {31'h0, mem_write_o}, {31'h0, mw});
        check({tag, " zero_o"},      {31'h0, zero_o},      {31'h0, exp_zero});
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " valid_o"}, {31'h0, valid_o}, 32'h0);
        check_beat(tag, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Per-cycle table: inputs applied this cycle, outputs expected this
        // cycle (i.e. the result of earlier rows).
        //             fl  vi  rdy  alu          st           rd  rw mr mw  eRdy eVal eAlu         eSt          eRd eRw eMr eMw
        vecs.push_back(mk(0, 0, 1, 32'h0,        32'h0,       0,  0, 0, 0,  1, 0, 32'h0,        32'h0,       0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h10,       32'hAAAA,    5,  1, 0, 0,  1, 0, 32'h0,        32'h0,       0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,        32'h0,       0,  0, 0, 0,  1, 1, 32'h10,       32'hAAAA,    5,  1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h1,        32'h44,      0,  1, 1, 0,  1, 0, 32'h0,        32'h0,       0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h0,        32'h55,      7,  1, 0, 1,  1, 1, 32'h1,        32'h44,      0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,        32'h0,       0,  0, 0, 0,  1, 1, 32'h0,        32'h55,      7,  1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h11,       32'h1,       1,  1, 0, 0,  1, 0, 32'h0,        32'h0,       0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h22,       32'h2,       2,  0, 1, 0,  1, 1, 32'h11,       32'h1,       1,  1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h99,       32'h3,       3,  1, 0, 1,  0, 1, 32'h11,       32'h1,       1,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,        32'h0,       0,  0, 0, 0,  0, 1, 32'h11,       32'h1,       1,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,        32'h0,       0,  0, 0, 0,  1, 1, 32'h22,       32'h2,       2,  0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,        32'h0,       0,  0, 0, 0,  1, 0, 32'h0,        32'h0,       0,  0, 0, 0));

        // Reset: ready_o low and everything cleared while rst_i is high.
        rst_i = 1'b1;
        send(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
        #1;
        check("reset ready_o", {31'h0, ready_o}, 32'h0);
        check_cleared("reset");
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check("post-reset ready_o", {31'h0, ready_o}, 32'h1);

        // Table-driven cycles.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #1;
            check($sformatf("row%0d ready_o", i), {31'h0, ready_o}, {31'h0, vecs[i].e_ready});
            check($sformatf("row%0d valid_o", i), {31'h0, valid_o}, {31'h0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                check_beat($sformatf("row%0d", i), vecs[i].e_alu, vecs[i].e_st, vecs[i].e_rd,
                           vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw);
            end
            tick();
        end

        // Flush while full with a beat also offered: nothing survives.
        send(1'b1, 1'b0, 1'b0, 32'hD0, 5'd4);
        tick();
        send(1'b1, 1'b0, 1'b0, 32'hE0, 5'd6);
        tick();
        #1;
        check("flush pre ready_o", {31'h0, ready_o}, 32'h0);
        check("flush pre alu_data_o", alu_data_o, 32'hD0);
        send(1'b1, 1'b0, 1'b1, 32'hF0, 5'd8);
        tick();
        send(1'b0, 1'b1, 1'b0, 32'h0, 5'd0);
        #1;
        check("flush valid_o", {31'h0, valid_o}, 32'h0);
        check("flush ready_o", {31'h0, ready_o}, 32'h1);
        tick();
        check("flush drained valid_o", {31'h0, valid_o}, 32'h0);

        // Asynchronous reset in the middle of a stall, asserted off-edge.
        send(1'b1, 1'b0, 1'b0, 32'hA5, 5'd9);
        tick();
        send(1'b1, 1'b0, 1'b0, 32'hB6, 5'd10);
        tick();
        send(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
        #1;
        check("stall pre-reset ready_o", {31'h0, ready_o}, 32'h0);
        #1;
        rst_i = 1'b1;
        #1;
        check("mid-stall reset ready_o", {31'h0, ready_o}, 32'h0);
        check_cleared("mid-stall reset");
        tick();
        #2;
        rst_i = 1'b0;
        #1;
        check("reset release ready_o", {31'h0, ready_o}, 32'h1);
        check("reset release valid_o", {31'h0, valid_o}, 32'h0);

        // Stage still works after recovery.
        drive(mk(0, 1, 1, 32'hC3, 32'h77, 5'd12, 1'b1, 1'b1, 1'b0,
                 0, 0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
        tick();
        send(1'b0, 1'b1, 1'b0, 32'h0, 5'd0);
        #1;
        check("recover valid_o", {31'h0, valid_o}, 32'h1);
        check_beat("recover", 32'hC3, 32'h77, 5'd12, 1'b1, 1'b1, 1'b0);
        tick();
        check("recover drained valid_o", {31'h0, valid_o}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
